ncore_rst_seq: RTL and testbench
================================

# ncore_rst_seq

Reset synchronizer and staged reset-release sequencer. It consumes the free-running testbench clock and the active-low raw reset from the clock/reset generator. It produces `NUM_RST` ordered, active-low reset outputs for the Ncore sub-blocks, and checks that the DUT signals init completion within a timeout. It also supports a software-requested re-sequence without a global reset.

## Interface
- `SYNC_STAGES`, 2: flops in the reset-deassertion synchronizer; minimum 2.
- `NUM_RST`, 4: number of staged reset outputs; range 1..8.
- `STAGE_GAP`, 8: cycles between successive releases, and the software-reset hold length; minimum 1.
- `INIT_TIMEOUT`, 1024: cycles allowed for `init_done` after the last release; minimum 1.
- `clk_fr`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low. Assertion takes effect immediately; deassertion passes through the synchronizer.
- `sw_rst_req`, input, 1: software re-sequence request, sampled each cycle.
- `init_done`, input, 1: DUT initialisation complete, level, sampled each cycle.
- `rst_out_n`, output, `NUM_RST`: staged active-low resets; bit 0 is released first.
- `seq_busy`, output, 1: a sequence is in progress.
- `seq_done`, output, 1: the sequence completed and `init_done` was seen.
- `init_timeout`, output, 1: sticky flag; `init_done` was not seen within `INIT_TIMEOUT` cycles.
- `seq_cnt`, output, 8: number of sequences that reached DONE.

## Operation
- **States:** RST_HOLD (reset state), SW_HOLD, RELEASE, WAIT_INIT, DONE, TIMEOUT.
- **Reset values** (while `rst`=0, forced asynchronously): state RST_HOLD, synchronizer all 0, `rst_out_n`=0, `seq_busy`=0, `seq_done`=0, `init_timeout`=0, `seq_cnt`=0, all counters 0.
- **RST_HOLD:** waits for the synchronizer's last flop to be 1, then moves to RELEASE with the gap counter at 0.
- **RELEASE:**
  - The gap counter increments every cycle.
  - When it reaches `STAGE_GAP`-1: set `rst_out_n[idx]`=1, increment `idx`, clear the counter.
  - Releasing `idx`=`NUM_RST`-1 moves the FSM to WAIT_INIT at that same edge and clears the timeout counter.
  - Once a bit is released it stays 1 until `rst` or a software reset.
- **WAIT_INIT:**
  - If `init_done` is sampled 1: go to DONE, set `seq_done`=1, increment `seq_cnt` (wraps 255 to 0).
  - Otherwise, after `INIT_TIMEOUT` cycles without `init_done`: go to TIMEOUT and set `init_timeout`=1.
- **DONE / TIMEOUT:** hold all outputs.
- **Software reset:**
  - `sw_rst_req` sampled 1 in DONE or TIMEOUT, at that edge: `rst_out_n`=0, `seq_done`=0, `init_timeout`=0, go to SW_HOLD.
  - After `STAGE_GAP` cycles in SW_HOLD, go to RELEASE.
  - This path bypasses the synchronizer.
  - `sw_rst_req` is ignored in RST_HOLD, SW_HOLD, RELEASE and WAIT_INIT.
- **`seq_busy`:** 1 in SW_HOLD, RELEASE and WAIT_INIT; 0 otherwise.
- **Output timing:** all outputs are registered; `rst_out_n` comes straight from flops, with no combinational path from `rst` other than the asynchronous clear.

## Timing
- **Edge numbering:** edge 1 is the first `clk_fr` rising edge with `rst`=1.
- **Synchronizer:** output is 1 after edge `SYNC_STAGES`; RELEASE is entered at edge `SYNC_STAGES`+1.
- **Release edges:** `rst_out_n[i]` rises at edge `SYNC_STAGES`+1+(i+1)·`STAGE_GAP`.
  - With defaults: bit 0 at edge 11, bit 1 at 19, bit 2 at 27, bit 3 at 35.
  - `seq_busy` rises at edge 3.
- **WAIT_INIT timing:** WAIT_INIT is entered at edge T.
  - `init_done` is sampled at edges T+1 through T+`INIT_TIMEOUT`.
  - With no `init_done`, `init_timeout` rises at edge T+`INIT_TIMEOUT`.
  - If `init_done` is 1 at edge T+`INIT_TIMEOUT`, DONE wins.
- **Software reset at edge S:** `rst_out_n[i]` rises at S+(i+2)·`STAGE_GAP`.
- **Reset mid-sequence:** `rst` going low in any state immediately returns everything to its reset values. A low pulse shorter than one cycle still fully resets the block, and the full sequence restarts on the next deassertion.
- **`init_done` timing:** `init_done` high before WAIT_INIT is entered has no effect.
- **Timeout latency:** `INIT_TIMEOUT`=1 means only edge T+1 is sampled.

## Test plan
- **Power-on sequence.** Stimulus: defaults; `rst` low for 5 cycles, then high; `init_done` tied to 1. Required response:
  - `rst_out_n` steps 0000, 0001, 0011, 0111, 1111 at edges 11, 19, 27, 35.
  - `seq_done`=1 at edge 36; `seq_cnt`=1.
- **Init timeout.** Stimulus: `INIT_TIMEOUT`=16, `init_done`=0. Required response: `init_timeout` rises at edge 51; `seq_done` stays 0; `seq_busy` falls at edge 51.
- **Timeout/init_done tie.** Stimulus: `INIT_TIMEOUT`=16; `init_done` pulses only at edge 51. Required response: DONE, `seq_done`=1, `init_timeout`=0.
- **Software reset.** Stimulus: from DONE, `sw_rst_req` pulse at edge S=100. Required response:
  - `rst_out_n`=0000 after edge 100.
  - Bits rise at edges 116, 124, 132, 140.
  - `seq_cnt`=2 after `init_done`.
- **Request while busy.** Stimulus: `sw_rst_req` held high during RELEASE. Required response: release timing identical to the power-on case.
- **Reset mid-sequence.** Stimulus: `rst` low for 0.3 cycle at edge 22 (`rst_out_n`=0011). Required response:
  - All outputs go to 0 immediately.
  - The sequence restarts with bit 0 released 11 edges after `rst` returns high.
  - `seq_cnt` is cleared to 0.

Source files
------------

// File: rtl/ncore_rst_seq.sv
// rtl/ncore_rst_seq.sv - reset synchronizer and staged reset-release sequencer
// Releases NUM_RST active-low resets in order, then waits for init_done with a timeout.
module ncore_rst_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int NUM_RST      = 4,
  parameter int STAGE_GAP    = 8,
  parameter int INIT_TIMEOUT = 1024
) (
  input  logic               clk_fr,
  input  logic               rst,
  input  logic               sw_rst_req,
  input  logic               init_done,
  output logic [NUM_RST-1:0] rst_out_n,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               init_timeout,
  output logic [7:0]         seq_cnt
);

  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int TW = $clog2(INIT_TIMEOUT + 1);
  localparam int IW = $clog2(NUM_RST + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(STAGE_GAP - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(INIT_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_RST - 1);

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    SW_HOLD   = 3'd1,
    RELEASE   = 3'd2,
    WAIT_INIT = 3'd3,
    DONE      = 3'd4,
    TIMEOUT   = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic [GW-1:0]      gap_cnt;
  logic [GW-1:0]      gap_nxt;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_nxt;
  logic [TW-1:0]      tmo_cnt;
  logic [TW-1:0]      tmo_nxt;
  logic [NUM_RST-1:0] rst_out_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               tmo_flag_nxt;
  logic [7:0]         cnt_nxt;
  logic               gap_hit;
  logic               last_rel;
  logic               tmo_hit;

  // Assertion clears the chain at once; deassertion ripples through SYNC_STAGES flops.
  always_ff @(posedge clk_fr or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign gap_hit  = (gap_cnt == GAP_LAST);
  assign last_rel = gap_hit && (idx == IDX_LAST);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_fr or negedge rst) begin
    if (!rst) begin
      state        <= RST_HOLD;
      gap_cnt      <= '0;
      idx          <= '0;
      tmo_cnt      <= '0;
      rst_out_n    <= '0;
      seq_busy     <= 1'b0;
      seq_done     <= 1'b0;
      init_timeout <= 1'b0;
      seq_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      gap_cnt      <= gap_nxt;
      idx          <= idx_nxt;
      tmo_cnt      <= tmo_nxt;
      rst_out_n    <= rst_out_nxt;
      seq_busy     <= busy_nxt;
      seq_done     <= done_nxt;
      init_timeout <= tmo_flag_nxt;
      seq_cnt      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RST_HOLD:  if (sync[SYNC_STAGES-1]) state_nxt = RELEASE;
      SW_HOLD:   if (gap_hit) state_nxt = RELEASE;
      RELEASE:   if (last_rel) state_nxt = WAIT_INIT;
      WAIT_INIT: begin
        // init_done wins a tie with the final timeout cycle.
        if (init_done)    state_nxt = DONE;
        else if (tmo_hit) state_nxt = TIMEOUT;
      end
      DONE, TIMEOUT: if (sw_rst_req) state_nxt = SW_HOLD;
      default:   state_nxt = RST_HOLD;
    endcase
  end

  always_comb begin
    gap_nxt      = gap_cnt;
    idx_nxt      = idx;
    tmo_nxt      = tmo_cnt;
    rst_out_nxt  = rst_out_n;
    done_nxt     = seq_done;
    tmo_flag_nxt = init_timeout;
    cnt_nxt      = seq_cnt;
    case (state)
      RST_HOLD: begin
        gap_nxt = '0;
        idx_nxt = '0;
      end
      SW_HOLD: begin
        gap_nxt = gap_hit ? '0 : gap_cnt + 1'b1;
      end
      RELEASE: begin
        if (gap_hit) begin
          for (int i = 0; i < NUM_RST; i++) begin
            if (idx == IW'(i)) rst_out_nxt[i] = 1'b1;
          end
          idx_nxt = idx + 1'b1;
          gap_nxt = '0;
          if (last_rel) tmo_nxt = '0;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      WAIT_INIT: begin
        if (init_done) begin
          done_nxt = 1'b1;
          cnt_nxt  = seq_cnt + 8'd1;
        end else if (tmo_hit) begin
          tmo_flag_nxt = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      DONE, TIMEOUT: begin
        if (sw_rst_req) begin
          rst_out_nxt  = '0;
          done_nxt     = 1'b0;
          tmo_flag_nxt = 1'b0;
          gap_nxt      = '0;
          idx_nxt      = '0;
        end
      end
      default: begin
      end
    endcase
  end

  assign busy_nxt = state_nxt inside {SW_HOLD, RELEASE, WAIT_INIT};

endmodule

// File: tb/tb_ncore_rst_seq.sv
// tb/tb_ncore_rst_seq.sv - randomized self-checking bench for ncore_rst_seq
module tb_ncore_rst_seq;

  localparam int SYNC = 2;
  localparam int NRST = 4;
  localparam int GAP  = 8;
  localparam int TMO  = 16;

  logic            clk_fr = 1'b0;
  logic            rst = 1'b0;
  logic            sw_rst_req = 1'b0;
  logic            init_done = 1'b0;
  logic [NRST-1:0] rst_out_n;
  logic            seq_busy;
  logic            seq_done;
  logic            init_timeout;
  logic [7:0]      seq_cnt;

  ncore_rst_seq #(
    .SYNC_STAGES  (SYNC),
    .NUM_RST      (NRST),
    .STAGE_GAP    (GAP),
    .INIT_TIMEOUT (TMO)
  ) dut (
    .clk_fr       (clk_fr),
    .rst          (rst),
    .sw_rst_req   (sw_rst_req),
    .init_done    (init_done),
    .rst_out_n    (rst_out_n),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .init_timeout (init_timeout),
    .seq_cnt      (seq_cnt)
  );

  always #5 clk_fr = ~clk_fr;

  int n_checks = 0;
  int n_errors = 0;

  // Timeline model: k counts edges since rst rose; base is the edge release counting starts.
  int k;
  int base;
  int busy_from;
  int outcome;
  int cnt;

  int pe[5] = '{10, 11, 19, 27, 35};
  int se[5] = '{115, 116, 124, 132, 140};
  int pv[5] = '{0, 1, 3, 7, 15};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d (t=%0t): got %0h, expected %0h", tag, k, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    k         = 0;
    base      = SYNC + 1;
    busy_from = SYNC + 1;
    outcome   = 0;
    cnt       = 0;
  endtask

  task automatic model_edge(input logic sw, input logic ini);
    int t_wait;
    k++;
    t_wait = base + NRST * GAP;
    if (outcome != 0) begin
      if (sw) begin
        outcome   = 0;
        busy_from = k;
        base      = k + GAP;
      end
    end else if (k > t_wait && k <= t_wait + TMO) begin
      if (ini) begin
        outcome = 1;
        cnt     = (cnt + 1) % 256;
      end else if (k == t_wait + TMO) begin
        outcome = 2;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NRST-1:0] exp_rst;
    for (int i = 0; i < NRST; i++) exp_rst[i] = (outcome != 0) || (k >= base + (i + 1) * GAP);
    check("rst_out_n", 32'(rst_out_n), 32'(exp_rst));
    check("seq_busy", 32'(seq_busy), 32'(outcome == 0 && k >= busy_from));
    check("seq_done", 32'(seq_done), 32'(outcome == 1));
    check("init_timeout", 32'(init_timeout), 32'(outcome == 2));
    check("seq_cnt", 32'(seq_cnt), 32'(cnt));
  endtask

  task automatic cycle(input logic sw, input logic ini);
    @(negedge clk_fr);
    sw_rst_req = sw;
    init_done  = ini;
    @(posedge clk_fr);
    if (rst) model_edge(sw, ini);
    #1 check_outputs();
  endtask

  task automatic start_seq();
    rst = 1'b0;
    model_reset();
    repeat (5) cycle(1'b0, 1'b0);
    rst = 1'b1;
  endtask

  // 0.3-cycle low pulse placed between clock edges.
  task automatic pulse_rst();
    rst = 1'b0;
    model_reset();
    #1 check_outputs();
    #2 rst = 1'b1;
  endtask

  initial begin
    // Power-on with init_done tied high, then a software re-sequence at edge 100.
    start_seq();
    check("reset_rst_out", 32'(rst_out_n), 32'd0);
    while (k < 99) begin
      cycle(1'b0, 1'b1);
      for (int j = 0; j < 5; j++) if (k == pe[j]) check("pwr_step", 32'(rst_out_n), 32'(pv[j]));
      if (k == 36) begin
        check("pwr_done", 32'(seq_done), 32'd1);
        check("pwr_cnt", 32'(seq_cnt), 32'd1);
      end
    end
    cycle(1'b1, 1'b1);
    check("sw_clear", 32'(rst_out_n), 32'd0);
    while (k < 150) begin
      cycle(1'b0, 1'b1);
      for (int j = 0; j < 5; j++) if (k == se[j]) check("sw_step", 32'(rst_out_n), 32'(pv[j]));
    end
    check("sw_cnt", 32'(seq_cnt), 32'd2);

    // Timeout with init_done held low.
    start_seq();
    while (k < 60) begin
      cycle(1'b0, 1'b0);
      if (k == 50) check("tmo_busy50", 32'(seq_busy), 32'd1);
      if (k == 51) begin
        check("tmo_busy51", 32'(seq_busy), 32'd0);
        check("tmo_rise51", 32'(init_timeout), 32'd1);
      end
    end
    check("tmo_done", 32'(seq_done), 32'd0);

    // init_done only on the final timeout edge.
    start_seq();
    while (k < 60) cycle(1'b0, logic'(k + 1 == 51));
    check("tie_done", 32'(seq_done), 32'd1);
    check("tie_tmo", 32'(init_timeout), 32'd0);

    // sw_rst_req held during RELEASE must not disturb the timing.
    start_seq();
    while (k < 40) begin
      cycle(logic'(k + 1 <= 35), 1'b1);
      for (int j = 0; j < 5; j++) if (k == pe[j]) check("busy_step", 32'(rst_out_n), 32'(pv[j]));
    end

    // Short reset pulse mid-sequence after one completed sequence.
    cycle(1'b1, 1'b1);
    while (k < 66) cycle(1'b0, 1'b1);
    check("mid_pre", 32'(rst_out_n), 32'd3);
    check("mid_pre_cnt", 32'(seq_cnt), 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    check("mid_rst_out", 32'(rst_out_n), 32'd0);
    check("mid_busy", 32'(seq_busy), 32'd0);
    check("mid_cnt", 32'(seq_cnt), 32'd0);
    #2 rst = 1'b1;
    while (k < 12) begin
      cycle(1'b0, 1'b1);
      if (k == 10) check("mid_edge10", 32'(rst_out_n), 32'd0);
      if (k == 11) check("mid_edge11", 32'(rst_out_n), 32'd1);
    end

    // Random traffic with occasional short reset pulses.
    start_seq();
    repeat (3000) begin
      cycle(logic'($urandom_range(15) == 0), logic'($urandom_range(7) == 0));
      if ($urandom_range(299) == 0) pulse_rst();
    end

    // Dense re-sequencing so seq_cnt wraps past 255.
    start_seq();
    repeat (14000) cycle(logic'($urandom_range(2) == 0), logic'($urandom_range(1) == 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
